// File: rtl/qif_synapse_driver.sv
// Synaptic current source for the QIF neuron: four spike lines with programmable
// weights feed a saturating accumulator that decays exponentially on a prescaled tick.
module qif_synapse_driver #(
  parameter int unsigned DECAY_PERIOD = 16,
  parameter int unsigned DECAY_SHIFT  = 3,
  parameter int unsigned ACC_W        = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] spike_in,
  input  logic       w_we,
  input  logic [1:0] w_addr,
  input  logic [7:0] w_data,
  output logic [7:0] i_syn,
  output logic       i_syn_sat
);

  localparam int unsigned PS_W  = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int unsigned SUM_W = ACC_W + 3;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(DECAY_PERIOD - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [3:0]       spike_prev_q, spike_prev_d;
  logic [7:0]       w_q [4];
  logic [7:0]       w_d [4];

  logic             tick;
  logic [3:0]       ev;
  logic [ACC_W-1:0] dec_amt;
  logic [ACC_W-1:0] dec_val;
  logic [SUM_W-1:0] sum;

  // Weight file update; a same-edge spike still sees the old weight in w_q.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_d[k] = w_q[k];
    end
    if (w_we) begin
      w_d[w_addr] = w_data;
    end
  end

  // Prescaler, edge detect, decay-then-add with saturation.
  always_comb begin
    spike_prev_d = spike_in;
    ev           = spike_in & ~spike_prev_q;
    tick         = ena && (ps_q == PS_LAST);
    ps_d         = ps_q;
    acc_d        = acc_q;
    dec_amt      = acc_q >> DECAY_SHIFT;
    dec_val      = acc_q;
    sum          = '0;

    // Force a minimum step of 1 so small values decay all the way to zero.
    if (tick && (acc_q != '0) && (dec_amt == '0)) begin
      dec_amt = ACC_W'(1);
    end
    if (tick) begin
      dec_val = acc_q - dec_amt;
    end

    sum = SUM_W'(dec_val);
    for (int k = 0; k < 4; k++) begin
      if (ev[k]) begin
        sum = sum + SUM_W'(w_q[k]);
      end
    end

    if (ena) begin
      ps_d  = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
      acc_d = (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : sum[ACC_W-1:0];
    end
  end

  // State registers; spike history updates even while disabled so held lines are not replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      ps_q         <= '0;
      spike_prev_q <= '0;
      for (int k = 0; k < 4; k++) begin
        w_q[k] <= '0;
      end
    end else begin
      acc_q        <= acc_d;
      ps_q         <= ps_d;
      spike_prev_q <= spike_prev_d;
      for (int k = 0; k < 4; k++) begin
        w_q[k] <= w_d[k];
      end
    end
  end

  // Output clip to the neuron's 8-bit current range.
  always_comb begin
    i_syn_sat = (acc_q > ACC_W'(255));
    i_syn     = i_syn_sat ? 8'hFF : acc_q[7:0];
  end

endmodule
